// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register-index constants used by the destination-select
// mux and the register file.
package cpu_defs;

  localparam int          NUM_REGS = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_AT   = 5'd1;
  localparam logic [4:0]  REG_V0   = 5'd2;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [4:0]  REG_FP   = 5'd30;
  localparam logic [4:0]  REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_sb_popcount.sv
// Combinational population count of the scoreboard's pending vector.
module sb_popcount
  import cpu_defs::*;
#(
  parameter int N = NUM_REGS,
  parameter int W = $clog2(NUM_REGS + 1)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + W'(vec[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// General-purpose register file with write-first bypass and a per-register
// pending-write scoreboard for the hazard unit.
module reg_file_sb
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              pend1,
  output logic              pend2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_live;

  assign wr_live = we && (wa != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[wa] <= wd;
    end
  end

  // A new issue supersedes a retiring write to the same register.
  always_comb begin
    pending_nxt = pending;
    for (int i = 1; i < NREGS; i++) begin
      if (issue_en && (issue_addr == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b1;
      end else if (we && (wa == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
    pending_nxt[0] = 1'b0;
  end

  sb_popcount #(
    .N (NREGS),
    .W (ADDR_W + 1)
  ) u_popcount (
    .vec (pending_nxt),
    .cnt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Bypass is gated by reset so a write presented during reset is invisible.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rst_n) begin
      if (ra1 != ADDR_W'(REG_ZERO)) begin
        rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
      end
      if (ra2 != ADDR_W'(REG_ZERO)) begin
        rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
      end
    end
  end

  always_comb begin
    pend1 = rst_n && pending[ra1] &&
            !(we && (wa == ra1) && !(issue_en && (issue_addr == ra1)));
    pend2 = rst_n && pending[ra2] &&
            !(we && (wa == ra2) && !(issue_en && (issue_addr == ra2)));
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb: comb outputs are checked just
// before each rising edge, after the vector's inputs have settled.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, issue_addr, dbg_addr;
  logic [31:0] rd1, rd2, wd, dbg_data;
  logic        pend1, pend2, we, issue_en;
  logic [5:0]  pend_cnt;

  int nApplied;
  int nMiscompares;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_p1;
    logic        e_p2;
    logic [31:0] e_dbg;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [23];

  reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .pend1      (pend1),
    .pend2      (pend2),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pend_cnt   (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic w, input logic [4:0] a, input logic [31:0] d,
    input logic ie, input logic [4:0] ia,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dg,
    input logic [31:0] x1, input logic [31:0] x2,
    input logic p1, input logic p2, input logic [31:0] xd, input logic [5:0] c);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.ie = ie; v.ia = ia;
    v.ra1 = r1; v.ra2 = r2; v.dbg = dg;
    v.e_rd1 = x1; v.e_rd2 = x2; v.e_p1 = p1; v.e_p2 = p2;
    v.e_dbg = xd; v.e_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we = v.we; wa = v.wa; wd = v.wd;
    issue_en = v.ie; issue_addr = v.ia;
    ra1 = v.ra1; ra2 = v.ra2; dbg_addr = v.dbg;
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    nApplied++;
    check($sformatf("v%0d rd1", idx), rd1, v.e_rd1);
    check($sformatf("v%0d rd2", idx), rd2, v.e_rd2);
    check($sformatf("v%0d pend1", idx), 32'(pend1), 32'(v.e_p1));
    check($sformatf("v%0d pend2", idx), 32'(pend2), 32'(v.e_p2));
    check($sformatf("v%0d dbg_data", idx), dbg_data, v.e_dbg);
    check($sformatf("v%0d pend_cnt", idx), 32'(pend_cnt), 32'(v.e_cnt));
  endtask

  initial begin
    nApplied = 0;
    nMiscompares = 0;
    rst_n = 1'b0;
    we = 0; wa = 0; wd = 0; issue_en = 0; issue_addr = 0;
    ra1 = 0; ra2 = 0; dbg_addr = 0;

    //              we wa  wd            ie ia  ra1 ra2 dbg  rd1           rd2           p1 p2 dbg           cnt
    vecs[0]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  0,   32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[1]  = mk(1, 8,  32'hDEADBEEF, 0, 0,  8,  0,  8,   32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0);
    vecs[2]  = mk(0, 0,  32'h0,        0, 0,  8,  0,  8,   32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 9,  32'h1234,     0, 0,  0,  9,  9,   32'h0,        32'h1234,     0, 0, 32'h0,        0);
    vecs[4]  = mk(0, 0,  32'h0,        0, 0,  0,  9,  9,   32'h0,        32'h1234,     0, 0, 32'h1234,     0);
    vecs[5]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,   32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[6]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  0,   32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[7]  = mk(0, 0,  32'h0,        1, 3,  0,  0,  0,   32'h0,        32'h0,        0, 0, 32'h0,        0);
    vecs[8]  = mk(0, 0,  32'h0,        1, 4,  3,  0,  0,   32'h0,        32'h0,        1, 0, 32'h0,        1);
    vecs[9]  = mk(0, 0,  32'h0,        1, 5,  4,  0,  0,   32'h0,        32'h0,        1, 0, 32'h0,        2);
    vecs[10] = mk(0, 0,  32'h0,        0, 0,  4,  5,  0,   32'h0,        32'h0,        1, 1, 32'h0,        3);
    vecs[11] = mk(1, 4,  32'hAAAA0004, 0, 0,  4,  3,  0,   32'hAAAA0004, 32'h0,        0, 1, 32'h0,        3);
    vecs[12] = mk(0, 0,  32'h0,        0, 0,  4,  5,  0,   32'hAAAA0004, 32'h0,        0, 1, 32'h0,        2);
    vecs[13] = mk(0, 0,  32'h0,        1, 7,  0,  0,  0,   32'h0,        32'h0,        0, 0, 32'h0,        2);
    vecs[14] = mk(0, 0,  32'h0,        0, 0,  7,  0,  0,   32'h0,        32'h0,        1, 0, 32'h0,        3);
    vecs[15] = mk(1, 7,  32'h77777777, 1, 7,  7,  0,  7,   32'h77777777, 32'h0,        1, 0, 32'h0,        3);
    vecs[16] = mk(0, 0,  32'h0,        0, 0,  7,  0,  7,   32'h77777777, 32'h0,        1, 0, 32'h77777777, 3);
    vecs[17] = mk(0, 0,  32'h0,        1, 3,  3,  0,  0,   32'h0,        32'h0,        1, 0, 32'h0,        3);
    vecs[18] = mk(0, 0,  32'h0,        0, 0,  3,  0,  0,   32'h0,        32'h0,        1, 0, 32'h0,        3);
    vecs[19] = mk(1, 20, 32'h5,        0, 0,  20, 0,  0,   32'h5,        32'h0,        0, 0, 32'h0,        3);
    vecs[20] = mk(0, 0,  32'h0,        0, 0,  20, 8,  0,   32'h5,        32'hDEADBEEF, 0, 0, 32'h0,        3);
    vecs[21] = mk(1, 3,  32'h33,       1, 10, 3,  10, 0,   32'h33,       32'h0,        0, 0, 32'h0,        3);
    vecs[22] = mk(0, 0,  32'h0,        0, 0,  3,  10, 3,   32'h33,       32'h0,        0, 1, 32'h33,       3);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
      @(negedge clk);
    end

    // Reset mid-run with a write and issue presented: both must be discarded.
    we = 1; wa = 12; wd = 32'hCAFEF00D; issue_en = 1; issue_addr = 12;
    ra1 = 12; ra2 = 8; dbg_addr = 8;
    rst_n = 1'b0;
    #1;
    nApplied++;
    check("rst rd1", rd1, 32'h0);
    check("rst rd2", rd2, 32'h0);
    check("rst pend1", 32'(pend1), 32'h0);
    check("rst dbg_data", dbg_data, 32'h0);
    check("rst pend_cnt", 32'(pend_cnt), 32'h0);
    @(negedge clk);
    we = 0; issue_en = 0;
    rst_n = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(a); dbg_addr = 5'(a);
      #1;
      nApplied++;
      check($sformatf("post-rst rd1[%0d]", a), rd1, 32'h0);
      check($sformatf("post-rst rd2[%0d]", a), rd2, 32'h0);
      check($sformatf("post-rst pend1[%0d]", a), 32'(pend1), 32'h0);
      check($sformatf("post-rst dbg[%0d]", a), dbg_data, 32'h0);
    end
    check("post-rst pend_cnt", 32'(pend_cnt), 32'h0);

    // File is usable again after reset.
    @(negedge clk);
    we = 1; wa = 31; wd = 32'h0BADC0DE; issue_en = 1; issue_addr = 31;
    @(negedge clk);
    we = 0; issue_en = 0; ra1 = 31; dbg_addr = 31;
    #1;
    nApplied++;
    check("after-rst rd1", rd1, 32'h0BADC0DE);
    check("after-rst dbg", dbg_data, 32'h0BADC0DE);
    check("after-rst pend1", 32'(pend1), 32'h1);
    check("after-rst pend_cnt", 32'(pend_cnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
